logic_table_gen: RTL and testbench
==================================

# logic_table_gen

Parametrised, clocked truth-table generator for 2-input bitwise logic functions. It sweeps every combination of two W-bit operands in ascending order and applies a programmable 2-input function to each bit pair. Each row is emitted over a valid/ready handshake. It replaces per-function hand-written gate modules and their stimulus benches with one reusable sequential block that a bench or display stage can drain row by row.

## Interface

Parameters:
- W, 1 — operand width in bits; legal range 1..8.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-high; clears all state immediately.
- start  in  1  — begin a sweep; sampled only in IDLE.
- func  in  4  — function truth table: result bit = func[{a_bit, b_bit}]; captured at start.
- busy  out  1  — high in RUN and DONE.
- row_valid  out  1  — a row is presented on row_a / row_b / row_s.
- row_ready  in  1  — consumer accepts the row this cycle.
- row_a  out  W  — operand a of the current row.
- row_b  out  W  — operand b of the current row.
- row_s  out  W  — bitwise result: row_s[i] = func_q[{row_a[i], row_b[i]}].
- done  out  1  — one-cycle pulse after the last row is accepted.
- hit_count  out  2W+1  — present only with MINTERM_COUNT_EN; see Configuration.

## Operation

- Row index cnt is 2W bits wide, with row_a = cnt[2W-1:W] and row_b = cnt[W-1:0], so a is the high half. For W=1 the order is (0,0), (0,1), (1,0), (1,1).
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN on start=1:
  - func_q is loaded from func.
  - cnt is set to 0.
  - hit_count is cleared.
- RUN: row_valid=1. A handshake is row_valid & row_ready.
  - On a handshake with cnt < 2^(2W)-1: cnt increments.
  - On a handshake with cnt = 2^(2W)-1: go to DONE and drop row_valid. cnt does not wrap or restart.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored in RUN and DONE. Changes on func after capture have no effect until the next start.
- Without a handshake, row_a, row_b, row_s and row_valid hold stable. No row is skipped or repeated.
- row_s is combinational from cnt and func_q, so it changes only when cnt or func_q changes.

## Timing

- Reset values:
  - State is IDLE; cnt and func_q are 0.
  - busy, row_valid and done are 0.
  - row_a, row_b and row_s are 0.
  - hit_count is 0.
- start is sampled at edge k. row_valid and busy are high from edge k onward, and row 0 is visible in cycle k+1.
- With row_ready held at 1, one row is accepted per cycle. The last handshake is at edge k+2^(2W).
- done is high in the cycle after the last handshake. busy falls together with done.
- The earliest next start is accepted in the cycle after done.
- Reset asserted mid-sweep forces all outputs to their reset values without waiting for a clock edge. After release the block is in IDLE and a new start begins again at row 0.
- Simultaneous start and reset: reset wins.

## Configuration

- MINTERM_COUNT_EN defined:
  - The hit_count port exists.
  - It increments on each handshake whose row_s is all ones (&row_s).
  - It is cleared at start and holds its final value from done until the next start.
  - Its width of 2W+1 covers the maximum of 2^(2W) without overflow.
- MINTERM_COUNT_EN undefined: the hit_count port and its counter are absent. All other behaviour is identical.

## Test plan

- Reset: assert reset asynchronously mid-cycle. All outputs are 0 at once, before the next edge. After release, busy=0 and row_valid=0.
- W=1, func=4'b0010 (a̅·b), row_ready=1. Rows (a,b,s) are (0,0,0), (0,1,1), (1,0,0), (1,1,0) on four consecutive cycles. done pulses once in the next cycle, and hit_count=1.
- Backpressure, W=1, func=4'b0110: hold row_ready=0 for 3 cycles while row (0,1) is shown. The row stays (0,1,1) with row_valid=1 throughout. After release the sequence continues with (1,0,1), with no skip or duplicate.
- W=2, func=4'b0110 (XOR), row_ready=1: 16 rows are emitted. Row a=2'b10, b=2'b11 gives s=2'b01. At done, hit_count=4.
- Ignored inputs, W=1: pulse start with func=4'b1000 during RUN after an initial start with func=4'b0001. The sweep continues with func_q=4'b0001 and does not restart.
- Mid-sweep reset, W=2: assert reset after 5 handshakes. All outputs are 0 immediately. A new start with func=4'b1110 begins at (0,0) with s=2'b00, runs all 16 rows and ends with hit_count=9.

Source files
------------

// File: rtl/logic_table_gen.sv
// rtl/logic_table_gen.sv - truth-table sweep generator for 2-input bitwise functions
//
// Purpose: sweeps every {a,b} pair of two W-bit operands in ascending order
// (a is the high half of the row index) and emits one row per valid/ready
// handshake with row_s[i] = func_q[{row_a[i], row_b[i]}].
// Optional feature macro: MINTERM_COUNT_EN adds hit_count, the number of
// accepted rows whose result is all ones.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   begin a sweep (sampled in IDLE only)
//   func       in   4-bit function truth table, captured at start
//   busy       out  high in RUN and DONE
//   row_valid  out  a row is presented
//   row_ready  in   consumer accepts the row this cycle
//   row_a      out  operand a of the current row
//   row_b      out  operand b of the current row
//   row_s      out  bitwise function result of the current row
//   done       out  one-cycle pulse after the last row is accepted
//   hit_count  out  all-ones row count (MINTERM_COUNT_EN only)

module logic_table_gen #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   func,
  output logic         busy,
  output logic         row_valid,
  input  logic         row_ready,
  output logic [W-1:0] row_a,
  output logic [W-1:0] row_b,
  output logic [W-1:0] row_s,
  output logic         done
`ifdef MINTERM_COUNT_EN
  ,
  output logic [2*W:0] hit_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2*W-1:0] CNT_MAX = {(2*W){1'b1}};
  localparam logic [2*W-1:0] CNT_ONE = {{(2*W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_next;
  logic [2*W-1:0]   r_cnt;
  logic [3:0]       r_func;
  logic             w_hs;
  logic             w_last;
  logic             w_load;
  logic [W-1:0]     w_row_s;

  // Each result bit looks up the captured truth table with its own bit pair.
  always_comb begin
    w_row_s = '0;
    for (int i = 0; i < W; i++) begin
      w_row_s[i] = r_func[{r_cnt[W+i], r_cnt[i]}];
    end
  end

  assign row_a = r_cnt[2*W-1:W];
  assign row_b = r_cnt[W-1:0];
  assign row_s = w_row_s;

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    row_valid    = 1'b0;
    done         = 1'b0;
    w_hs         = 1'b0;
    w_load       = 1'b0;
    w_last       = (r_cnt == CNT_MAX);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        w_hs      = row_ready;
        if (row_ready && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_func  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cnt  <= '0;
        r_func <= func;
      end else if (w_hs && !w_last) begin
        // The final row keeps its index: cnt never wraps back to zero.
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

`ifdef MINTERM_COUNT_EN
  localparam logic [2*W:0] HIT_ONE = {{(2*W){1'b0}}, 1'b1};

  logic [2*W:0] r_hit_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count <= '0;
    end else if (w_load) begin
      r_hit_count <= '0;
    end else if (w_hs && (&w_row_s)) begin
      r_hit_count <= r_hit_count + HIT_ONE;
    end
  end

  assign hit_count = r_hit_count;
`endif

endmodule

// File: tb/tb_logic_table_gen.sv
// tb/tb_logic_table_gen.sv - randomized and directed bench for logic_table_gen (W=1 and W=2)

module tb_logic_table_gen;

  logic       clk;
  logic       reset;
  logic       start1;
  logic       start2;
  logic [3:0] func;
  logic       row_ready;

  logic       busy1, valid1, done1;
  logic [0:0] a1, b1, s1;
  logic       busy2, valid2, done2;
  logic [1:0] a2, b2, s2;
`ifdef MINTERM_COUNT_EN
  logic [2:0] hit1;
  logic [4:0] hit2;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  logic_table_gen #(.W(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .func(func),
    .busy(busy1), .row_valid(valid1), .row_ready(row_ready),
    .row_a(a1), .row_b(b1), .row_s(s1), .done(done1)
`ifdef MINTERM_COUNT_EN
    , .hit_count(hit1)
`endif
  );

  logic_table_gen #(.W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .func(func),
    .busy(busy2), .row_valid(valid2), .row_ready(row_ready),
    .row_a(a2), .row_b(b2), .row_s(s2), .done(done2)
`ifdef MINTERM_COUNT_EN
    , .hit_count(hit2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase 0=idle 1=run 2=done, plain integer row index.
  int         m_ph[2];
  int         m_cnt[2];
  int         m_hits[2];
  logic [3:0] m_fq[2];

  function automatic int wof(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int s_of(input logic [3:0] f, input int c, input int w);
    int a, b, s, idx;
    a = c >> w;
    b = c & ((1 << w) - 1);
    s = 0;
    for (int j = 0; j < w; j++) begin
      idx = (((a >> j) & 1) * 2) + ((b >> j) & 1);
      if (f[idx]) s = s | (1 << j);
    end
    return s;
  endfunction

  function automatic logic [31:0] exp_vec(input int i);
    int w, c, v;
    w = wof(i);
    c = m_cnt[i];
    v = 0;
    if (m_ph[i] != 0) v = v | (1 << (3*w + 2));
    if (m_ph[i] == 1) v = v | (1 << (3*w + 1));
    if (m_ph[i] == 2) v = v | (1 << (3*w));
    v = v | (c << w) | s_of(m_fq[i], c, w);
    return 32'(v);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_ph[i] = 0; m_cnt[i] = 0; m_hits[i] = 0; m_fq[i] = 4'd0;
      end else begin
        case (m_ph[i])
          0: if ((i == 0) ? start1 : start2) begin
               m_ph[i] = 1; m_cnt[i] = 0; m_hits[i] = 0; m_fq[i] = func;
             end
          1: if (row_ready) begin
               if (s_of(m_fq[i], m_cnt[i], wof(i)) == (1 << wof(i)) - 1) m_hits[i]++;
               if (m_cnt[i] == (1 << (2*wof(i))) - 1) m_ph[i] = 2;
               else m_cnt[i]++;
             end
          default: m_ph[i] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("model_w1", 32'({busy1, valid1, done1, a1, b1, s1}), exp_vec(0));
    chk("model_w2", 32'({busy2, valid2, done2, a2, b2, s2}), exp_vec(1));
`ifdef MINTERM_COUNT_EN
    chk("hits_w1", 32'(hit1), 32'(m_hits[0]));
    chk("hits_w2", 32'(hit2), 32'(m_hits[1]));
`endif
  end

  task automatic nx;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int which, input string nm);
    int k;
    k = 0;
    while (((which == 1) ? done1 : done2) !== 1'b1 && k < 60) begin
      nx;
      k++;
    end
    chk(nm, 32'(k < 60), 32'd1);
  endtask

  logic [2:0] e_nb[4];

  initial begin
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; func = 4'd0; row_ready = 1'b0;
    e_nb = '{3'b000, 3'b011, 3'b100, 3'b110};
    #1;
    chk("reset_w1", 32'({busy1, valid1, done1, a1, b1, s1}), 32'd0);
    chk("reset_w2", 32'({busy2, valid2, done2, a2, b2, s2}), 32'd0);
    nx; nx;
    reset = 1'b0;
    nx;
    chk("idle_after_rst", 32'({busy1, valid1, busy2, valid2}), 32'd0);

    // W=1, a'b, ready held high
    start1 = 1'b1; func = 4'b0010; row_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      nx;
      if (r == 0) start1 = 1'b0;
      chk("nb_row", 32'({valid1, a1, b1, s1}), 32'({1'b1, e_nb[r]}));
    end
    nx;
    chk("nb_done", 32'(done1), 32'd1);
`ifdef MINTERM_COUNT_EN
    chk("nb_hits", 32'(hit1), 32'd1);
`endif
    nx;
    chk("nb_done_pulse", 32'({done1, busy1}), 32'd0);

    // Backpressure on row (0,1)
    start1 = 1'b1; func = 4'b0110;
    nx; start1 = 1'b0;
    chk("bp_row0", 32'({a1, b1, s1}), 32'b000);
    nx; chk("bp_row1", 32'({valid1, a1, b1, s1}), 32'b1011);
    row_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      nx;
      chk("bp_hold", 32'({valid1, a1, b1, s1}), 32'b1011);
    end
    row_ready = 1'b1;
    nx; chk("bp_next", 32'({valid1, a1, b1, s1}), 32'b1101);
    wait_done(1, "bp_done_seen");
    nx;

    // W=2 XOR
    start2 = 1'b1; func = 4'b0110;
    nx; start2 = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (r > 0) nx;
      if (r == 11) chk("xor_row11", 32'({a2, b2, s2}), 32'b10_11_01);
    end
    nx;
    chk("xor_done", 32'(done2), 32'd1);
`ifdef MINTERM_COUNT_EN
    chk("xor_hits", 32'(hit2), 32'd4);
`endif
    nx;

    // start/func ignored during RUN
    start1 = 1'b1; func = 4'b0001;
    nx; chk("ign_row0", 32'({a1, b1, s1}), 32'b001);
    start1 = 1'b1; func = 4'b1000;
    nx; start1 = 1'b0;
    chk("ign_row1", 32'({a1, b1, s1}), 32'b010);
    nx; chk("ign_row2", 32'({a1, b1, s1}), 32'b100);
    nx; chk("ign_row3", 32'({a1, b1, s1}), 32'b110);
    nx; chk("ign_done", 32'(done1), 32'd1);
    nx;

    // Mid-sweep async reset on W=2
    start2 = 1'b1; func = 4'b0110;
    nx; start2 = 1'b0;
    for (int r = 0; r < 5; r++) nx;
    chk("mr_row5", 32'({a2, b2}), 32'b0101);
    #1 reset = 1'b1;
    #1;
    chk("mr_zero", 32'({busy2, valid2, done2, a2, b2, s2}), 32'd0);
    reset = 1'b0;
    nx;
    start2 = 1'b1; func = 4'b1110;
    nx; start2 = 1'b0;
    chk("mr_row0", 32'({valid2, a2, b2, s2}), 32'b1_00_00_00);
    wait_done(2, "mr_done_seen");
`ifdef MINTERM_COUNT_EN
    chk("mr_hits", 32'(hit2), 32'd9);
`endif
    nx;

    // Randomized traffic, including occasional async reset pulses
    for (int c = 0; c < 3000; c++) begin
      nx;
      row_ready = ($urandom_range(0, 3) != 0);
      start1    = ($urandom_range(0, 7) == 0);
      start2    = ($urandom_range(0, 15) == 0);
      func      = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    nx;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
